// File: rtl/onchip_mem_loader_pkg.sv
// Shared types and default geometry for the on-chip memory loader.
// Defaults match the 512 x 32 single-port memory of the NIOS tester.
package onchip_mem_loader_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 512;
  localparam int DEF_CNT_W  = 12;

  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int WORD_W     = LANES * LANE_W;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/onchip_mem_loader_if.sv
// Byte-stream input and Avalon-MM write port of the loader, bundled together.
// The master modport is the loader side; slave is the stream source plus memory.
interface onchip_mem_loader_if
  import onchip_mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [LANE_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  logic [ADDR_W-1:0] m_address;
  logic [LANES-1:0]  m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [WORD_W-1:0] m_writedata;

  modport master (
    input  s_data,
    input  s_valid,
    output s_ready,
    output m_address,
    output m_byteenable,
    output m_chipselect,
    output m_write,
    output m_writedata
  );

  modport slave (
    output s_data,
    output s_valid,
    input  s_ready,
    input  m_address,
    input  m_byteenable,
    input  m_chipselect,
    input  m_write,
    input  m_writedata
  );

endinterface

// File: rtl/onchip_mem_loader_word_packer.sv
// Packs incoming bytes little-endian into one memory word and tracks which
// lanes have been filled since the last clear.
module loader_word_packer
  import onchip_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [LANE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic [LANES-1:0]  byteenable,
  output logic              full
);

  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [LANES-1:0]      be_q, be_d;

  // Clearing zeroes the data too, so unfilled lanes of a short tail word read 0.
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    be_d   = be_q;
    if (clear) begin
      lane_d = '0;
      word_d = '0;
      be_d   = '0;
    end else if (load) begin
      word_d[lane_q*LANE_W +: LANE_W] = din;
      be_d[lane_q]                    = 1'b1;
      lane_d                          = lane_q + LANE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane_q <= '0;
      word_q <= '0;
      be_q   <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      be_q   <= be_d;
    end
  end

  // full means the next load lands in the top lane and completes the word.
  assign full       = (lane_q == LANE_IDX_W'(LANES - 1));
  assign word       = word_q;
  assign byteenable = be_q;

endmodule

// File: rtl/onchip_mem_loader.sv
// Loads a byte stream into on-chip memory as 32-bit little-endian words,
// starting at a programmed word address, one write cycle per packed word.
module onchip_mem_loader
  import onchip_mem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   byte_count,
  output logic               busy,
  output logic               done,
  output logic               error,
  onchip_mem_loader_if.master bus
);

  localparam int CHK_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              error_q, error_d;

  logic              pk_load, pk_clear, pk_full;
  logic [WORD_W-1:0] pk_word;
  logic [LANES-1:0]  pk_be;

  logic [CHK_W-1:0]  cnt_ext, words_needed, end_word;
  logic              cmd_reject;
  logic              wr_cycle;

  loader_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (pk_load),
    .clear      (pk_clear),
    .din        (bus.s_data),
    .word       (pk_word),
    .byteenable (pk_be),
    .full       (pk_full)
  );

  // Widened so base + ceil(count/4) cannot overflow before the DEPTH compare.
  always_comb begin
    cnt_ext      = CHK_W'(byte_count);
    words_needed = (cnt_ext + CHK_W'(LANES - 1)) >> LANE_IDX_W;
    end_word     = CHK_W'(base_addr) + words_needed;
    cmd_reject   = (cnt_ext > CHK_W'(LANES * DEPTH)) || (end_word > CHK_W'(DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    error_d     = 1'b0;
    pk_load     = 1'b0;
    pk_clear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cmd_reject) begin
            error_d = 1'b1;
          end else if (byte_count == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_d      = base_addr;
            remaining_d = byte_count;
            pk_clear    = 1'b1;
            state_d     = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (bus.s_valid) begin
          pk_load     = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          if (pk_full || (remaining_q == CNT_W'(1))) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d   = addr_q + ADDR_W'(1);
        pk_clear = 1'b1;
        state_d  = (remaining_q != '0) ? ST_COLLECT : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      error_q     <= error_d;
    end
  end

  // Bus outputs decode registered state only; the bus reads 0 outside write cycles.
  assign wr_cycle = (state_q == ST_WRITE);

  always_comb begin
    bus.s_ready      = (state_q == ST_COLLECT);
    bus.m_chipselect = wr_cycle;
    bus.m_write      = wr_cycle;
    bus.m_address    = wr_cycle ? addr_q  : '0;
    bus.m_byteenable = wr_cycle ? pk_be   : '0;
    bus.m_writedata  = wr_cycle ? pk_word : '0;
    busy             = (state_q != ST_IDLE);
    done             = (state_q == ST_DONE);
    error            = error_q;
  end

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Directed bench for onchip_mem_loader with a word-level write scoreboard
// and a memory image model.
module tb_onchip_mem_loader;
  import onchip_mem_loader_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int CNT_W  = 12;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  byte_count = '0;
  logic              busy, done, error;

  onchip_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  onchip_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int done_cyc = -1;
  int wr_cyc[$];
  int acc_cyc[$];
  wr_t exp_q[$];
  logic [7:0]  stim[$];
  logic [31:0] mem_dut [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: every write cycle must match the next expected word.
  always @(negedge clk) begin
    if (reset_n) begin
      check("cs_equals_write", bus.m_chipselect, bus.m_write);
      if (bus.m_write === 1'b1) begin
        wr_t e;
        wr_cnt++;
        wr_cyc.push_back(cyc);
        check("ready_low_in_write", bus.s_ready, 1'b0);
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", bus.m_address, e.addr);
          check("wr_data", bus.m_writedata, e.data);
          check("wr_be", bus.m_byteenable, e.be);
        end
        for (int l = 0; l < 4; l++)
          if (bus.m_byteenable[l]) mem_dut[bus.m_address][l*8 +: 8] = bus.m_writedata[l*8 +: 8];
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (error === 1'b1) err_cnt++;
    end
  end

  // Expected words straight from the byte list: byte i goes to word i/4, lane i%4.
  task automatic model_expect(input int base);
    int n, nw;
    wr_t w;
    n  = stim.size();
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w.addr = ADDR_W'(base + k);
      w.data = '0;
      w.be   = '0;
      for (int l = 0; l < 4; l++) begin
        if (k*4 + l < n) begin
          w.data = w.data | (32'(stim[k*4 + l]) << (8*l));
          w.be   = w.be | (4'b1 << l);
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic run_cmd(input int base, input int count, output int t);
    start      = 1'b1;
    base_addr  = ADDR_W'(base);
    byte_count = CNT_W'(count);
    t          = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int gap_pct, input int limit);
    int idx = 0;
    int guard = 0;
    while (idx < stim.size() && guard < limit) begin
      bus.s_valid = ($urandom_range(99) >= gap_pct);
      bus.s_data  = bus.s_valid ? stim[idx] : 8'($urandom);
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.s_valid = 1'b0;
    check("feed_all_bytes", idx, stim.size());
  endtask

  task automatic wait_idle(input int limit, output int idle_at);
    int n = 0;
    idle_at = -1;
    while (n < limit && idle_at < 0) begin
      @(negedge clk);
      if (busy === 1'b0) idle_at = cyc;
      n++;
    end
    check("idle_reached", idle_at >= 0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_cs"}, bus.m_chipselect, 0);
    check({tag, "_write"}, bus.m_write, 0);
    check({tag, "_addr"}, bus.m_address, 0);
    check({tag, "_be"}, bus.m_byteenable, 0);
    check({tag, "_wdata"}, bus.m_writedata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, idle_at, w0, d0, e0, wc0, a0, bad;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full load, no bubbles: exact cycle placement of writes and done.
    stim = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    model_expect(0);
    check("model_w0", exp_q[0].data, 32'h04030201);
    check("model_w1", exp_q[1].data, 32'h08070605);
    d0 = done_cnt; e0 = err_cnt; wc0 = wr_cyc.size(); a0 = acc_cyc.size();
    run_cmd(0, 8, t);
    feed(0, 100);
    wait_idle(50, idle_at);
    check("full_first_accept", acc_cyc[a0], t + 1);
    check("full_fourth_accept", acc_cyc[a0 + 3], t + 4);
    check("full_write0_cycle", wr_cyc[wc0], t + 5);
    check("full_write1_cycle", wr_cyc[wc0 + 1], t + 10);
    check("full_done_cycle", done_cyc, t + 11);
    check("full_idle_cycle", idle_at, t + 12);
    check("full_done_count", done_cnt - d0, 1);
    check("full_no_error", err_cnt - e0, 0);
    check("full_queue_empty", exp_q.size(), 0);

    // Partial tail word.
    stim = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    model_expect(16);
    check("model_tail_data", exp_q[1].data, 32'h0000FFEE);
    check("model_tail_be", exp_q[1].be, 4'h3);
    d0 = done_cnt; w0 = wr_cnt;
    run_cmd(16, 6, t);
    feed(30, 200);
    wait_idle(50, idle_at);
    check("tail_writes", wr_cnt - w0, 2);
    check("tail_done_count", done_cnt - d0, 1);
    check("tail_queue_empty", exp_q.size(), 0);

    // Last word of memory is legal.
    stim = {8'h11, 8'h22, 8'h33, 8'h44};
    model_expect(511);
    w0 = wr_cnt; e0 = err_cnt;
    run_cmd(511, 4, t);
    feed(0, 50);
    wait_idle(50, idle_at);
    check("b511_writes", wr_cnt - w0, 1);
    check("b511_mem", mem_dut[511], 32'h44332211);
    check("b511_no_error", err_cnt - e0, 0);

    // One byte past the end is rejected.
    w0 = wr_cnt;
    run_cmd(511, 5, t);
    @(negedge clk);
    check("b511x5_error_T1", error, 1'b1);
    check("b511x5_busy_T1", busy, 1'b0);
    @(negedge clk);
    check("b511x5_error_T2", error, 1'b0);
    check("b511x5_busy_T2", busy, 1'b0);
    @(posedge clk); #1;
    check("b511x5_no_write", wr_cnt - w0, 0);

    // Zero-length command.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    run_cmd(0, 0, t);
    @(negedge clk);
    check("zero_done_T1", done, 1'b1);
    @(negedge clk);
    check("zero_done_T2", done, 1'b0);
    @(posedge clk); #1;
    check("zero_no_write", wr_cnt - w0, 0);
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_no_error", err_cnt - e0, 0);

    // Oversize command.
    run_cmd(0, 2049, t);
    @(negedge clk);
    check("over_error_T1", error, 1'b1);
    check("over_busy_T1", busy, 1'b0);
    @(posedge clk); #1;

    // Whole memory through random bubbles.
    stim.delete();
    for (int i = 0; i < 2048; i++) stim.push_back(8'($urandom));
    model_expect(0);
    d0 = done_cnt; w0 = wr_cnt; e0 = err_cnt;
    run_cmd(0, 2048, t);
    feed(40, 20000);
    wait_idle(50, idle_at);
    check("bulk_writes", wr_cnt - w0, 512);
    check("bulk_done_count", done_cnt - d0, 1);
    check("bulk_no_error", err_cnt - e0, 0);
    check("bulk_queue_empty", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 2048; i++)
      if (mem_dut[i/4][(i%4)*8 +: 8] !== stim[i]) bad++;
    check("bulk_image_bad_bytes", bad, 0);

    // Reset after three of four bytes: nothing written, no done.
    stim = {8'h91, 8'h92, 8'h93};
    w0 = wr_cnt; d0 = done_cnt;
    run_cmd(32, 4, t);
    feed(0, 50);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_write", wr_cnt - w0, 0);
    check("midrst_no_done", done_cnt - d0, 0);

    stim = {8'h5A, 8'hA5, 8'hC3, 8'h3C};
    model_expect(48);
    w0 = wr_cnt; d0 = done_cnt;
    run_cmd(48, 4, t);
    feed(20, 100);
    wait_idle(50, idle_at);
    check("after_rst_writes", wr_cnt - w0, 1);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_queue_empty", exp_q.size(), 0);
    check("after_rst_mem", mem_dut[48], 32'h3CC3A55A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_loader.md
# onchip_mem_loader

Upstream write master for the 512 x 32 single-port on-chip memory of the NIOS tester. Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words and writes them through the memory's Avalon-MM slave port starting at a programmed word address. Used to load the test image or patch data before the CPU is released.

## Interface
- ADDR_W, 9, memory word-address width
- DEPTH, 512, memory depth in words
- CNT_W, 12, width of the byte count; maximum legal transfer is 4*DEPTH bytes
- clk  in  1  system clock
- reset_n  in  1  one clock; reset is synchronous and active-low
- start  in  1  single-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on start
- byte_count  in  CNT_W  number of bytes to load, latched on start
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts a byte this cycle
- m_address  out  ADDR_W  memory word address
- m_byteenable  out  4  lane enables, bit i = writedata[8i+7:8i]
- m_chipselect  out  1  memory select, high only on write cycles
- m_write  out  1  write strobe, equal to m_chipselect
- m_writedata  out  32  packed word
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle pulse at transfer end
- error  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: on start, check the command. Reject if byte_count > 4*DEPTH, or if base_addr + ceil(byte_count/4) > DEPTH; a rejected start pulses error next cycle and stays in IDLE. If byte_count = 0, go to DONE. Otherwise latch base_addr and byte_count, clear lane index and byte-enable accumulator, and go to COLLECT.
- COLLECT: s_ready=1. On s_valid&s_ready, store the byte in lane = lane index, set that lane's enable bit, increment the lane index and decrement the remaining count. Go to WRITE when lane 3 is filled or the last byte is taken.
- WRITE: m_chipselect=m_write=1 for exactly one cycle, with m_address = current word address, m_byteenable = accumulated lanes and m_writedata = packed word. Unfilled lanes are driven 0. s_ready=0. Then increment the address, clear the lanes, and go to COLLECT if bytes remain, else to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address never wraps: the start check guarantees the last write is at or below DEPTH-1.
- start outside IDLE is ignored, with no error.
- s_data is ignored unless s_ready=1.

## Timing
- Reset values: s_ready=0, m_chipselect=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0, busy=0, done=0, error=0, state IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from s_valid to any output.
- start at cycle T moves to COLLECT at T+1, where s_ready=1.
- The 4th byte of a word is accepted at cycle N; the write occurs at N+1; COLLECT resumes at N+2. Sustained rate is 4 bytes per 5 cycles.
- The memory has no waitrequest, so a write completes in its strobe cycle.
- The last write is at cycle W, done pulses at W+1, and the block is back in IDLE at W+2. busy falls at W+2.
- byte_count=0: done pulses at T+1.
- Rejected start: error pulses at T+1.
- Reset mid-transfer: at the first clock edge with reset_n=0, the state returns to IDLE and all outputs take their reset values. A partially collected word is discarded and not written, and done is not pulsed.

## Structure
- Package onchip_mem_loader_pkg holds:
  - the state enum type
  - ADDR_W, DEPTH and CNT_W defaults
  - the byte-lane count constant (4)
- Sub-module loader_word_packer holds the lane index, data shift-in and byte-enable accumulator.
  - Controls: load, clear.
  - Outputs: word, byteenable, full.
- The top level contains the FSM, the command check, the remaining-count counter and the address counter.

## Test plan
- Full load: base_addr=0, byte_count=8, bytes 01..08 -> two writes: addr 0, data 0x04030201, be 0xF; then addr 1, data 0x08070605, be 0xF. done once, no error.
- Partial tail: base_addr=0x10, byte_count=6, bytes AA BB CC DD EE FF -> writes at 0x10: 0xDDCCBBAA, be 0xF; then at 0x11: 0x0000FFEE, be 0x3.
- Boundary: base_addr=511, count=4 -> one write at 511. base_addr=511, count=5 -> error pulse, no write, busy stays 0.
- Zero and oversize: count=0 -> done at T+1, no write. count=2049 -> error at T+1.
- Backpressure and bubbles: random s_valid gaps; assert that s_ready=0 in every write cycle and that no byte is lost or duplicated, checked over 2048 bytes against a memory model.
- Reset mid-transfer: reset_n low after 3 of 4 bytes -> no write occurs, all outputs return to reset values, and a following start runs normally.
